// File: rtl/read_line_ctrl_pkg.sv
// Shared types and layout constants for the line-buffer read controller.
package read_line_ctrl_pkg;

   localparam int DEF_CHAR_WIDTH  = 11;
   localparam int DEF_LINE_WIDTH  = 3;

   // rd_ptr = {line, char}: char index sits in the low bits, line index above it
   localparam int RD_PTR_CHAR_LSB = 0;

   function automatic int rd_ptr_line_lsb(input int char_width);
      return RD_PTR_CHAR_LSB + char_width;
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } state_t;

endpackage

// File: rtl/read_line_ctrl_rd_ptr_gen.sv
// Line/char counter pair that forms the buffer read address.
module rd_ptr_gen #(
   parameter int CHAR_WIDTH = 11,
   parameter int LINE_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_char_inc,
   input  logic                  i_newline,
   output logic [CHAR_WIDTH-1:0] o_char,
   output logic [LINE_WIDTH-1:0] o_line
);

   logic [CHAR_WIDTH-1:0] r_char;
   logic [LINE_WIDTH-1:0] r_line;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_char <= '0;
         r_line <= '0;
      end else if (i_newline) begin
         r_char <= '0;
         r_line <= r_line + 1'b1;
      end else if (i_char_inc) begin
         r_char <= r_char + 1'b1;
      end
   end

   assign o_char = r_char;
   assign o_line = r_line;

endmodule

// File: rtl/read_line_ctrl.sv
// Reads committed lines out of a line buffer beat by beat with valid/ready backpressure.
// Optional line drop (rd_drop/out_drop) is built when RD_LINE_DROP_EN is defined.
module read_line_ctrl
   import read_line_ctrl_pkg::*;
#(
   parameter int CHAR_WIDTH = DEF_CHAR_WIDTH,
   parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_line_done,
   input  logic [CHAR_WIDTH-1:0]          wr_line_len_m1,
   output logic [LINE_WIDTH+CHAR_WIDTH-1:0] rd_ptr,
   output logic                           rd_en,
   output logic                           out_valid,
   output logic                           out_last,
   input  logic                           out_ready,
`ifdef RD_LINE_DROP_EN
   input  logic                           rd_drop,
   output logic                           out_drop,
`endif
   output logic                           buf_full,
   output logic [LINE_WIDTH:0]            lines_used,
   output logic                           err_ovf
);

   localparam int NLINES = 2**LINE_WIDTH;
   localparam logic [LINE_WIDTH:0] FULL_CNT = {1'b1, {LINE_WIDTH{1'b0}}};

   state_t                r_state, w_state_nxt;
   logic [CHAR_WIDTH-1:0] r_len [NLINES];
   logic [CHAR_WIDTH-1:0] r_rem;
   logic [LINE_WIDTH-1:0] r_wr_line_ptr;
   logic [LINE_WIDTH:0]   r_lines_used;
   logic                  r_err_ovf, r_out_valid, r_out_last;
   logic [CHAR_WIDTH-1:0] w_char;
   logic [LINE_WIDTH-1:0] w_line;
   logic                  w_full, w_commit, w_issue, w_last, w_load;
   logic                  w_char_inc, w_newline, w_drop;

`ifdef RD_LINE_DROP_EN
   assign w_drop   = (r_state == ST_READ) && rd_drop;
   assign out_drop = w_drop;
`else
   assign w_drop   = 1'b0;
`endif

   assign w_full     = (r_lines_used == FULL_CNT);
   assign w_commit   = wr_line_done && !w_full;
   assign w_last     = (r_rem == '0);
   assign w_char_inc = w_issue && !w_last;
   assign w_newline  = (w_issue && w_last) || w_drop;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_lines_used != '0) begin
               w_state_nxt = ST_READ;
               w_load      = 1'b1;
            end
         end
         ST_READ: begin
            if (w_drop) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_issue = !r_out_valid || out_ready;
               if (w_issue && w_last) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_wr_line_ptr <= '0;
         r_lines_used  <= '0;
         r_err_ovf     <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_last    <= 1'b0;
         r_rem         <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_commit) r_wr_line_ptr <= r_wr_line_ptr + 1'b1;
         if (wr_line_done && w_full) r_err_ovf <= 1'b1;
         case ({w_commit, w_newline})
            2'b10:   r_lines_used <= r_lines_used + 1'b1;
            2'b01:   r_lines_used <= r_lines_used - 1'b1;
            default: r_lines_used <= r_lines_used;
         endcase
         // r_rem counts beats still to issue after the current one
         if (w_load)          r_rem <= r_len[w_line];
         else if (w_char_inc) r_rem <= r_rem - 1'b1;
         if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   // Length table carries no reset; entries are only read after being committed.
   always_ff @(posedge clk) begin
      if (w_commit) r_len[r_wr_line_ptr] <= wr_line_len_m1;
   end

   rd_ptr_gen #(
      .CHAR_WIDTH (CHAR_WIDTH),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_rd_ptr_gen (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_char_inc (w_char_inc),
      .i_newline  (w_newline),
      .o_char     (w_char),
      .o_line     (w_line)
   );

   assign rd_ptr[RD_PTR_CHAR_LSB +: CHAR_WIDTH]             = w_char;
   assign rd_ptr[rd_ptr_line_lsb(CHAR_WIDTH) +: LINE_WIDTH] = w_line;
   assign rd_en      = w_issue;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign buf_full   = w_full;
   assign lines_used = r_lines_used;
   assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_read_line_ctrl.sv
// Bench for read_line_ctrl: directed scenarios plus random traffic against a queue-based line model.
module tb_read_line_ctrl;
   import read_line_ctrl_pkg::*;

   localparam int CW = DEF_CHAR_WIDTH;
   localparam int LW = DEF_LINE_WIDTH;
   localparam int NL = 1 << LW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_line_done = 1'b0;
   logic [CW-1:0] wr_line_len_m1 = '0;
   logic          out_ready = 1'b0;
   logic [LW+CW-1:0] rd_ptr;
   logic          rd_en, out_valid, out_last, buf_full, err_ovf;
   logic [LW:0]   lines_used;
`ifdef RD_LINE_DROP_EN
   logic          rd_drop = 1'b0;
   logic          out_drop;
`endif

   always #5 clk = ~clk;

   read_line_ctrl #(.CHAR_WIDTH(CW), .LINE_WIDTH(LW)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_line_done   (wr_line_done),
      .wr_line_len_m1 (wr_line_len_m1),
      .rd_ptr         (rd_ptr),
      .rd_en          (rd_en),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .out_ready      (out_ready),
`ifdef RD_LINE_DROP_EN
      .rd_drop        (rd_drop),
      .out_drop       (out_drop),
`endif
      .buf_full       (buf_full),
      .lines_used     (lines_used),
      .err_ovf        (err_ovf)
   );

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of committed line lengths, read position, presented beats
   int  q_len[$];
   bit  q_last[$];
   int  m_line = 0, m_char = 0;
   bit  m_err = 0;
   bit  mon_en = 0;
   bit  hold_prev = 0, gap_prev = 0;
   logic [LW+CW-1:0] prev_ptr;
   logic prev_last;
   int  iss_cnt = 0, acc_cnt = 0, last_acc_cnt = 0, both_cnt = 0;
   bit  m_done, m_commit, m_lastb, m_drop;

   always @(negedge clk) begin
      if (mon_en) begin
         m_done = 0;
         m_drop = 0;
         chk("lines_used", lines_used, q_len.size());
         chk("buf_full", buf_full, q_len.size() == NL);
         chk("err_ovf", err_ovf, m_err);
         chk("out_valid", out_valid, q_last.size() != 0);
         if (q_last.size() != 0) chk("out_last", out_last, q_last[0]);
         if (hold_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_last", out_last, prev_last);
            chk("hold_ptr", rd_ptr, prev_ptr);
         end
         if (out_valid && out_ready && q_last.size() != 0) begin
            acc_cnt++;
            m_lastb = q_last.pop_front();
            if (m_lastb) last_acc_cnt++;
         end
         if (rd_en) begin
            iss_cnt++;
            if (gap_prev) chk("line_gap", rd_en, 0);
            if (q_len.size() == 0) chk("rd_en_empty", rd_en, 0);
            else begin
               chk("rd_ptr", rd_ptr, {m_line[LW-1:0], m_char[CW-1:0]});
               q_last.push_back(m_char == q_len[0]);
               if (m_char == q_len[0]) begin
                  m_done = 1;
                  void'(q_len.pop_front());
                  m_line = (m_line + 1) % NL;
                  m_char = 0;
               end else m_char++;
            end
         end
         gap_prev = rd_en && m_done;
`ifdef RD_LINE_DROP_EN
         if (out_drop) begin
            m_drop = 1;
            if (q_len.size() == 0) chk("drop_empty", out_drop, 0);
            else begin
               m_done = 1;
               void'(q_len.pop_front());
               m_line = (m_line + 1) % NL;
               m_char = 0;
            end
         end
`endif
         hold_prev = out_valid && !out_ready && !m_drop;
         prev_ptr  = rd_ptr;
         prev_last = out_last;
         m_commit = wr_line_done && (q_len.size() < NL || m_done);
         // a completion in the same cycle does not free room for a commit
         if (wr_line_done && q_len.size() + (m_done ? 1 : 0) == NL) begin
            m_commit = 0;
            m_err = 1;
         end
         if (m_commit) q_len.push_back(int'(wr_line_len_m1));
         if (m_commit && m_done) both_cnt++;
         if (rst) begin
            q_len.delete();
            q_last.delete();
            m_line = 0; m_char = 0; m_err = 0;
            hold_prev = 0; gap_prev = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input int len_m1);
      wr_line_done   = 1'b1;
      wr_line_len_m1 = CW'(len_m1);
      tick();
      wr_line_done   = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while ((lines_used != 0 || out_valid) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, (lines_used != 0 || out_valid) ? 1 : 0, 0);
   endtask

   task automatic wait_acc(input int base, input int want, input string tag);
      int n = 0;
      while (acc_cnt - base < want && n < 100) begin
         tick();
         n++;
      end
      chk(tag, (acc_cnt - base >= want) ? 1 : 0, 1);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, l0, u0;
      tick();
      tick();
      mon_en = 1;
      chk("rst_rd_en", rd_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_lines_used", lines_used, 0);
      chk("rst_buf_full", buf_full, 0);
      chk("rst_err_ovf", err_ovf, 0);
      tick();
      rst = 1'b0;

      // four-beat line with downstream always ready
      out_ready = 1'b1;
      a0 = acc_cnt; l0 = last_acc_cnt;
      commit(3);
      chk("t030_used_after_commit", lines_used, 1);
      wait_idle(40, "t030_drain");
      chk("t030_beats", acc_cnt - a0, 4);
      chk("t030_lasts", last_acc_cnt - l0, 1);
      chk("t030_next_line", rd_ptr, {3'(1), 11'(0)});

      // five-cycle stall in the middle of an eight-beat line
      a0 = acc_cnt;
      commit(7);
      wait_acc(a0, 2, "t031_start");
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t031_stall_rd_en", rd_en, 0);
         chk("t031_stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      wait_idle(60, "t031_drain");
      chk("t031_beats", acc_cnt - a0, 8);

      // fill the buffer, overflow it, then drain and check the line wrap
      pulse_rst();
      out_ready = 1'b0;
      for (int i = 0; i <= NL; i++) commit(i == 0 ? 0 : int'($urandom_range(0, 5)));
      chk("t032_full_used", lines_used, NL);
      chk("t032_full_flag", buf_full, 1);
      chk("t032_no_err_yet", err_ovf, 0);
      commit(2);
      chk("t032_ovf_err", err_ovf, 1);
      chk("t032_ovf_used", lines_used, NL);
      out_ready = 1'b1;
      wait_idle(400, "t032_drain");
      chk("t032_wrap_line", rd_ptr, {3'((NL + 1) % NL), 11'(0)});
      chk("t032_err_sticky", err_ovf, 1);
      chk("t033_commit_and_done", both_cnt > 0 ? 1 : 0, 1);

      // reset in the middle of a line
      a0 = acc_cnt;
      commit(7);
      wait_acc(a0, 2, "t034_start");
      rst = 1'b1;
      tick();
      chk("t034_rd_en", rd_en, 0);
      chk("t034_out_valid", out_valid, 0);
      chk("t034_out_last", out_last, 0);
      chk("t034_rd_ptr", rd_ptr, 0);
      chk("t034_lines_used", lines_used, 0);
      chk("t034_buf_full", buf_full, 0);
      chk("t034_err_ovf", err_ovf, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t034_quiet", {rd_en, out_valid}, 0);
      end

`ifdef RD_LINE_DROP_EN
      // drop a six-beat line after its second beat
      a0 = iss_cnt;
      commit(5);
      for (int n = 0; n < 20 && iss_cnt - a0 < 2; n++) tick();
      chk("t035_two_issued", iss_cnt - a0, 2);
      rd_drop = 1'b1;
      u0 = int'(lines_used);
      chk("t035_out_drop", out_drop, 1);
      tick();
      rd_drop = 1'b0;
      chk("t035_used_dec", lines_used, u0 - 1);
      chk("t035_drop_pulse", out_drop, 0);
      commit(2);
      wait_idle(40, "t035_drain");
      chk("t035_total_issued", iss_cnt - a0, 5);
`else
      u0 = 0;
`endif

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         wr_line_done   = ($urandom_range(0, 99) < 15);
         wr_line_len_m1 = CW'($urandom_range(0, 6));
         out_ready      = ($urandom_range(0, 99) < 60);
         tick();
      end
      wr_line_done = 1'b0;
      out_ready    = 1'b1;
      wait_idle(2000, "rand_drain");
      tick();
      chk("rand_no_pending", q_last.size() + u0 * 0, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/read_line_ctrl.md
READ_LINE_CTRL -- requirements
Module: read_line_ctrl

Interface
REQ-001 SHALL have parameter CHAR_WIDTH, default 11, char index width; line holds up to 2**CHAR_WIDTH bytes.
REQ-002 SHALL have parameter LINE_WIDTH, default 3, line index width; buffer holds 2**LINE_WIDTH lines.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_line_done  in  1  one-cycle pulse: writer committed one line.
REQ-006 SHALL have port wr_line_len_m1  in  CHAR_WIDTH  committed line length minus 1, valid with wr_line_done.
REQ-007 SHALL have port rd_ptr  out  LINE_WIDTH+CHAR_WIDTH  buffer read address {line, char}.
REQ-008 SHALL have port rd_en  out  1  buffer read enable; buffer data valid next cycle and held while rd_en=0.
REQ-009 SHALL have port out_valid  out  1  beat presented downstream (buffer data passes through outside this block).
REQ-010 SHALL have port out_last  out  1  presented beat is last of line.
REQ-011 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-012 SHALL have port buf_full  out  1  all lines occupied.
REQ-013 SHALL have port lines_used  out  LINE_WIDTH+1  committed, unread line count.
REQ-014 SHALL have port err_ovf  out  1  sticky: commit received while full.

Function
REQ-015 SHALL keep per-line length table (2**LINE_WIDTH x CHAR_WIDTH), written at internal wr_line_ptr on wr_line_done when not full; wr_line_ptr wraps modulo 2**LINE_WIDTH.
REQ-016 SHALL update lines_used: +1 on accepted commit, -1 on line completion, unchanged when both occur in the same cycle; buf_full = (lines_used == 2**LINE_WIDTH).
REQ-017 SHALL ignore wr_line_done while buf_full (no table write, no count change) and set err_ovf; a simultaneous completion does not make the commit acceptable.
REQ-018 SHALL implement FSM IDLE/READ; IDLE->READ when lines_used!=0, loading remaining count from table[rd line]; READ->IDLE on the last-beat issue, giving one idle cycle between lines.
REQ-019 SHALL define issue = READ && (!out_valid || out_ready); rd_en = issue.
REQ-020 SHALL on a non-last issue pulse internal char increment; on the last issue pulse internal newline (char->0, line+1 modulo wrap), never both in one cycle.
REQ-021 SHALL register out_valid/out_last one cycle after issue; clear out_valid when out_ready && !issue; hold out_valid, out_last and rd_ptr while out_valid && !out_ready.
REQ-022 SHALL treat length-1 lines (len_m1=0) as a single beat with out_last=1.
REQ-023 SHALL count line completion (lines_used decrement) at the newline cycle, not at downstream acceptance.

Reset
REQ-024 SHALL on rst force: FSM IDLE, rd_ptr=0, wr_line_ptr=0, rd_en=0, out_valid=0, out_last=0, lines_used=0, buf_full=0, err_ovf=0; length table not reset.
REQ-025 SHALL abandon any line mid-read on rst with no further beats; rst overrides all inputs in the same cycle.

Configuration
REQ-026 SHALL with macro RD_LINE_DROP_EN defined add input rd_drop (1) and output out_drop (1): rd_drop in READ suppresses issue, pulses newline, decrements lines_used, returns to IDLE, pulses out_drop; a beat already presented stays with out_last=0 until accepted.
REQ-027 SHALL without RD_LINE_DROP_EN omit both ports and the drop logic; all lines are read in full.

Structure
REQ-028 SHALL place in shared package: FSM state enum, CHAR_WIDTH/LINE_WIDTH defaults, rd_ptr field layout constants.
REQ-029 SHALL instantiate one sub-module rd_ptr_gen (line/char counter pair: char increment, newline resets char and advances line, synchronous rst).

Verification
REQ-030 SHALL cover: commit len_m1=3, out_ready=1 -> rd_ptr char 0..3 in line 0, 4 beats, out_last on 4th, lines_used 1->0.
REQ-031 SHALL cover: out_ready=0 for 5 cycles mid-line -> rd_en=0, rd_ptr and out_valid held, no beat lost or duplicated.
REQ-032 SHALL cover: 8 commits (LINE_WIDTH=3), 9th commit -> buf_full=1, err_ovf=1, lines_used=8; read all 8 -> line pointer wraps to 0.
REQ-033 SHALL cover: commit and line completion in same cycle -> lines_used unchanged.
REQ-034 SHALL cover: rst asserted mid-line -> next cycle all outputs 0, FSM IDLE.
REQ-035 SHALL cover (RD_LINE_DROP_EN): rd_drop on beat 2 of 6-beat line -> out_drop pulse, next line starts at char 0, lines_used decremented once.
